// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Sequential bus initiator for the data memory. Copies a block of words from
//   a source range to a destination range (copy mode) or writes a constant over
//   a destination range (fill mode). Owns the memory port while Busy is high.
//
// Ports
//   clk        : single clock, rising-edge state updates
//   rst        : asynchronous active-low reset
//   Start      : request pulse, accepted only in IDLE
//   Mode       : 0 = copy, 1 = fill (latched at Start)
//   SrcAddr    : copy source base (latched at Start)
//   DstAddr    : destination base (latched at Start)
//   Length     : word count, 0 is a legal no-op (latched at Start)
//   FillData   : fill value (latched at Start)
//   Busy       : transfer in progress (RD/CAP/WR)
//   Done       : one-cycle completion pulse
//   Count      : words written in the current or last transfer
//   Address    : memory address
//   WriteData  : memory write data
//   MemWrite   : memory write strobe
//   MemRead    : memory read strobe
//   ReadData   : memory read data, registered by the memory on the MemRead edge
//
// Every output is registered and takes its value on the edge that enters the
// state it belongs to. Address arithmetic wraps modulo 2^DATA_DIR_WIDTH.
module mem_copy_engine #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DATA_DIR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic                      Mode,
  input  logic [DATA_DIR_WIDTH-1:0] SrcAddr,
  input  logic [DATA_DIR_WIDTH-1:0] DstAddr,
  input  logic [DATA_DIR_WIDTH-1:0] Length,
  input  logic [DATA_WIDTH-1:0]     FillData,
  output logic                      Busy,
  output logic                      Done,
  output logic [DATA_DIR_WIDTH-1:0] Count,
  output logic [DATA_DIR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]     WriteData,
  output logic                      MemWrite,
  output logic                      MemRead,
  input  logic [DATA_WIDTH-1:0]     ReadData
);

  localparam logic [DATA_DIR_WIDTH-1:0] ADDR_ONE = DATA_DIR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Transfer parameters captured at Start
  logic                      mode_q, mode_d;
  logic [DATA_DIR_WIDTH-1:0] src_q,  src_d;
  logic [DATA_DIR_WIDTH-1:0] dst_q,  dst_d;
  logic [DATA_DIR_WIDTH-1:0] len_q,  len_d;
  logic [DATA_WIDTH-1:0]     fill_q, fill_d;

  // Registered outputs; count_q doubles as the word index i
  logic                      busy_q,   busy_d;
  logic                      done_q,   done_d;
  logic [DATA_DIR_WIDTH-1:0] count_q,  count_d;
  logic [DATA_DIR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q,  wdata_d;
  logic                      mwrite_q, mwrite_d;
  logic                      mread_q,  mread_d;

  // Index of the word the next state operates on
  logic [DATA_DIR_WIDTH-1:0] idx_nxt;
  logic                      last_word;

  assign last_word = ((count_q + ADDR_ONE) == len_q);

  // State and all registered values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mwrite_q <= 1'b0;
      mread_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mwrite_q <= mwrite_d;
      mread_q  <= mread_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Length == '0) begin
            state_d = S_DONE;
          end else if (Mode) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_WR;
      S_WR: begin
        if (last_word) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values, decoded from the state being entered
  always_comb begin
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_nxt = count_q;

    busy_d   = (state_d == S_RD) || (state_d == S_CAP) || (state_d == S_WR);
    done_d   = (state_d == S_DONE);
    mread_d  = (state_d == S_RD);
    mwrite_d = (state_d == S_WR);

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = Length;
          fill_d  = FillData;
          count_d = '0;
          idx_nxt = '0;
        end
      end
      S_CAP: wdata_d = ReadData;
      S_WR: begin
        count_d = count_q + ADDR_ONE;
        idx_nxt = count_q + ADDR_ONE;
      end
      default: ;
    endcase

    // Bases come from the _d copies so the first strobe out of IDLE already
    // uses the values being latched on the same edge.
    if (state_d == S_RD) begin
      addr_d = src_d + idx_nxt;
    end
    if (state_d == S_WR) begin
      addr_d = dst_d + idx_nxt;
      if (mode_d) begin
        wdata_d = fill_d;
      end
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Count     = count_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;
  assign MemWrite  = mwrite_q;
  assign MemRead   = mread_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Self-checking bench for mem_copy_engine. Holds a behavioural data memory
//   attached to the DUT port and a reference memory image updated by plain
//   per-word copy/fill arithmetic. Each scenario task drives a transfer,
//   records a per-cycle trace (strobes, addresses, Busy/Done cycles) and
//   compares it with the cycle numbers and addresses derived from the
//   transfer parameters.
module tb_mem_copy_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Start = 1'b0;
  logic          Mode = 1'b0;
  logic [AW-1:0] SrcAddr = '0;
  logic [AW-1:0] DstAddr = '0;
  logic [AW-1:0] Length = '0;
  logic [DW-1:0] FillData = '0;
  logic          Busy, Done, MemWrite, MemRead;
  logic [AW-1:0] Count, Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  // Trace of the most recent transfer (cycle 1 = cycle after the Start edge)
  int            t_done_cyc, t_done_n, t_busy_n, t_busy_first, t_busy_last, t_both;
  logic [AW-1:0] t_count;
  logic [AW-1:0] rd_a[$];
  logic [AW-1:0] wr_a[$];
  int            rd_c[$];
  int            wr_c[$];

  mem_copy_engine #(
    .DATA_WIDTH     (DW),
    .DATA_DIR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Mode      (Mode),
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .Length    (Length),
    .FillData  (FillData),
    .Busy      (Busy),
    .Done      (Done),
    .Count     (Count),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData)
  );

  always #5 clk = ~clk;

  // Data memory: write on the strobe edge, read data registered on the read edge
  always @(posedge clk) begin
    if (MemWrite) mem[Address] = WriteData;
    if (MemRead) ReadData <= mem[Address];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
  endtask

  // Reference: words processed one at a time in ascending order
  task automatic apply_ref(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] l, input logic [DW-1:0] f);
    for (int k = 0; k < int'(l); k++) begin
      logic [AW-1:0] sa, da;
      sa = s + 8'(k);
      da = d + 8'(k);
      ref_mem[da] = m ? f : ref_mem[sa];
    end
  endtask

  // Drive one Start and record the trace until two cycles after Done (or a bound).
  // poke: pulse Start with junk parameters in every CAP cycle and in the DONE cycle.
  task automatic run_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input logic [DW-1:0] f, input bit poke);
    int lim;
    rd_a.delete(); wr_a.delete(); rd_c.delete(); wr_c.delete();
    t_done_cyc = -1; t_done_n = 0; t_busy_n = 0; t_busy_first = -1; t_busy_last = -1; t_both = 0;
    lim = 3 * int'(l) + 8;
    @(negedge clk);
    Mode = m; SrcAddr = s; DstAddr = d; Length = l; FillData = f; Start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (Busy) begin
        t_busy_n++;
        if (t_busy_first < 0) t_busy_first = c;
        t_busy_last = c;
      end
      if (Done) begin
        t_done_n++;
        if (t_done_cyc < 0) t_done_cyc = c;
      end
      if (MemRead) begin rd_a.push_back(Address); rd_c.push_back(c); end
      if (MemWrite) begin wr_a.push_back(Address); wr_c.push_back(c); end
      if (MemRead && MemWrite) t_both++;
      Start = 1'b0;
      if (c == 1) begin
        // parameter inputs wander while the transfer runs
        Mode = 1'($urandom); SrcAddr = 8'($urandom); DstAddr = 8'($urandom);
        Length = 8'($urandom); FillData = 8'($urandom);
      end
      if (poke && !m && l != 0 && (((c % 3) == 2 && c <= 3 * int'(l)) || c == 3 * int'(l) + 1))
        Start = 1'b1;
      if (t_done_cyc > 0 && c >= t_done_cyc + 2) break;
    end
    Start = 1'b0;
    t_count = Count;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b0; Start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Busy, Done, MemWrite, MemRead, Count, Address, WriteData} !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b mw=%b mr=%b cnt=%h addr=%h wd=%h, required all 0",
               Busy, Done, MemWrite, MemRead, Count, Address, WriteData);
    end
    rst = 1'b1;
    for (int i = 'h60; i <= 'h64; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    @(negedge clk);
    Mode = 1'b1; DstAddr = 8'h60; Length = 8'd5; FillData = 8'hC3; Start = 1'b1;
    @(negedge clk);  // cycle 1
    Start = 1'b0;
    @(negedge clk);  // cycle 2
    @(negedge clk);  // cycle 3: third write on the port, two already committed
    checks++;
    if ({MemWrite, Address, Count} !== {1'b1, 8'h62, 8'd2}) begin
      errors++;
      $display("FAIL reset_prefill_state: got mw=%b addr=%h cnt=%0d, required mw=1 addr=62 cnt=2",
               MemWrite, Address, Count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, MemWrite, MemRead, Count, Address, WriteData} !== '0) begin
      errors++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b mw=%b mr=%b cnt=%h addr=%h wd=%h, required all 0",
               Busy, Done, MemWrite, MemRead, Count, Address, WriteData);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (Done || Busy || MemWrite || MemRead) seen++; end
    rst = 1'b1;
    repeat (5) begin @(negedge clk); if (Done || Busy || MemWrite || MemRead) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d cycles with Done/Busy/strobe after abort, required 0", seen);
    end
    checks++;
    if ({mem['h60], mem['h61], mem['h62], mem['h63], mem['h64]} !== {8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_mem_words: got %h %h %h %h %h, required c3 c3 00 00 00",
               mem['h60], mem['h61], mem['h62], mem['h63], mem['h64]);
    end
  endtask

  task automatic test_copy();
    logic [DW-1:0] pat [4];
    int bad;
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    for (int k = 0; k < 4; k++) begin mem['h10 + k] = pat[k]; mem['h20 + k] = 8'h00; end
    run_xfer(1'b0, 8'h10, 8'h20, 8'd4, 8'h00, 1'b0);
    checks++;
    if (t_done_cyc != 13 || t_done_n != 1) begin
      errors++;
      $display("FAIL copy_done: got cycle %0d (%0d pulses), required cycle 13 (1 pulse)", t_done_cyc, t_done_n);
    end
    checks++;
    if (t_busy_n != 12 || t_busy_first != 1 || t_busy_last != 12) begin
      errors++;
      $display("FAIL copy_busy: got %0d cycles %0d..%0d, required 12 cycles 1..12", t_busy_n, t_busy_first, t_busy_last);
    end
    checks++;
    if (t_count !== 8'd4) begin
      errors++;
      $display("FAIL copy_count: got %0d, required 4", t_count);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) if (mem['h20 + k] !== pat[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL copy_data: got %h %h %h %h, required a1 b2 c3 d4", mem['h20], mem['h21], mem['h22], mem['h23]);
    end
  endtask

  task automatic test_fill();
    int bad;
    run_xfer(1'b1, 8'h00, 8'h40, 8'd3, 8'h5A, 1'b0);
    bad = 0;
    if (wr_a.size() != 3 || rd_a.size() != 0) bad++;
    else for (int k = 0; k < 3; k++) if (wr_a[k] !== 8'h40 + 8'(k) || wr_c[k] != k + 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_strobes: got %0d writes %0d reads, required writes at 40,41,42 in cycles 1..3 and no reads",
               wr_a.size(), rd_a.size());
    end
    checks++;
    if (t_done_cyc != 4 || t_done_n != 1) begin
      errors++;
      $display("FAIL fill_done: got cycle %0d (%0d pulses), required cycle 4 (1 pulse)", t_done_cyc, t_done_n);
    end
    checks++;
    if ({mem['h40], mem['h41], mem['h42]} !== {8'h5A, 8'h5A, 8'h5A}) begin
      errors++;
      $display("FAIL fill_data: got %h %h %h, required 5a 5a 5a", mem['h40], mem['h41], mem['h42]);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] a, b, c0;
    int bad;
    a = mem['hFE]; b = mem['hFF]; c0 = mem['h00];
    run_xfer(1'b0, 8'hFE, 8'h01, 8'd3, 8'h00, 1'b0);
    bad = 0;
    if (rd_a.size() != 3 || wr_a.size() != 3) bad++;
    else begin
      if ({rd_a[0], rd_a[1], rd_a[2]} !== {8'hFE, 8'hFF, 8'h00}) bad++;
      if ({wr_a[0], wr_a[1], wr_a[2]} !== {8'h01, 8'h02, 8'h03}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_addresses: got %0d reads %0d writes with bad order, required reads fe,ff,00 writes 01,02,03",
               rd_a.size(), wr_a.size());
    end
    checks++;
    if (t_both != 0) begin
      errors++;
      $display("FAIL wrap_exclusive: got %0d cycles with MemRead and MemWrite both high, required 0", t_both);
    end
    checks++;
    if ({mem['h01], mem['h02], mem['h03]} !== {a, b, c0}) begin
      errors++;
      $display("FAIL wrap_data: got %h %h %h, required %h %h %h", mem['h01], mem['h02], mem['h03], a, b, c0);
    end
  endtask

  task automatic test_zero_and_busy_start();
    run_xfer(1'b0, 8'h05, 8'h06, 8'd0, 8'h00, 1'b0);
    checks++;
    if (t_done_cyc != 1 || t_done_n != 1 || t_busy_n != 0 || rd_a.size() != 0 || wr_a.size() != 0) begin
      errors++;
      $display("FAIL zero_len: got done cycle %0d pulses %0d busy %0d reads %0d writes %0d, required 1 1 0 0 0",
               t_done_cyc, t_done_n, t_busy_n, rd_a.size(), wr_a.size());
    end
    checks++;
    if (t_count !== 8'd0) begin
      errors++;
      $display("FAIL zero_len_count: got %0d, required 0", t_count);
    end
    for (int k = 0; k < 3; k++) mem['h30 + k] = 8'h71 + 8'(k);
    run_xfer(1'b0, 8'h30, 8'h70, 8'd3, 8'h00, 1'b1);
    checks++;
    if (t_done_cyc != 10 || t_done_n != 1 || t_busy_n != 9 || t_busy_last != 9 || wr_a.size() != 3) begin
      errors++;
      $display("FAIL busy_start_ignored: got done %0d pulses %0d busy %0d last %0d writes %0d, required 10 1 9 9 3",
               t_done_cyc, t_done_n, t_busy_n, t_busy_last, wr_a.size());
    end
    checks++;
    if ({mem['h70], mem['h71], mem['h72]} !== {8'h71, 8'h72, 8'h73}) begin
      errors++;
      $display("FAIL busy_start_data: got %h %h %h, required 71 72 73", mem['h70], mem['h71], mem['h72]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (Count !== 8'd3 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL count_hold: got count %0d busy %b, required count 3 busy 0", Count, Busy);
    end
  endtask

  task automatic test_overlap();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
    run_xfer(1'b0, 8'h00, 8'h01, 8'd3, 8'h00, 1'b0);
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !== {8'h11, 8'h11, 8'h11, 8'h11, 8'h55}) begin
      errors++;
      $display("FAIL overlap_data: got %h %h %h %h %h, required 11 11 11 11 55",
               mem[0], mem[1], mem[2], mem[3], mem[4]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic          m;
      logic [AW-1:0] s, d, l;
      logic [DW-1:0] f;
      int            exp_done, exp_busy, bad;
      randomize_mem();
      m = 1'($urandom); s = 8'($urandom); d = 8'($urandom);
      l = 8'($urandom_range(0, 12)); f = 8'($urandom);
      apply_ref(m, s, d, l, f);
      run_xfer(m, s, d, l, f, 1'b0);
      exp_busy = (l == 0) ? 0 : (m ? int'(l) : 3 * int'(l));
      exp_done = exp_busy + 1;
      checks++;
      if (t_done_cyc != exp_done || t_done_n != 1 || t_busy_n != exp_busy || t_busy_last != (exp_busy == 0 ? -1 : exp_busy)) begin
        errors++;
        $display("FAIL rand%0d_timing: got done %0d pulses %0d busy %0d last %0d, required done %0d pulses 1 busy %0d",
                 n, t_done_cyc, t_done_n, t_busy_n, t_busy_last, exp_done, exp_busy);
      end
      bad = 0;
      if (rd_a.size() != (m ? 0 : int'(l)) || wr_a.size() != int'(l)) bad++;
      else begin
        for (int k = 0; k < rd_a.size(); k++)
          if (rd_a[k] !== s + 8'(k) || rd_c[k] != 3 * k + 1) bad++;
        for (int k = 0; k < wr_a.size(); k++)
          if (wr_a[k] !== d + 8'(k) || wr_c[k] != (m ? k + 1 : 3 * k + 3)) bad++;
      end
      checks++;
      if (bad != 0 || t_both != 0) begin
        errors++;
        $display("FAIL rand%0d_strobes: got %0d reads %0d writes %0d bad %0d overlapping, required %0d reads %0d writes in order",
                 n, rd_a.size(), wr_a.size(), bad, t_both, m ? 0 : int'(l), int'(l));
      end
      checks++;
      if (t_count !== l) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d, required %0d", n, t_count, l);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand%0d_memory: got %0d differing words (mode %b src %h dst %h len %0d), required 0",
                 n, bad, m, s, d, l);
      end
    end
  endtask

  initial begin
    randomize_mem();
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_zero_and_busy_start();
    test_overlap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
